// File: rtl/delta_alu_pipe_if.sv
// Operand/result bundle for delta_alu_pipe: sample stream in, registered result and flags out.
interface delta_alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             IN_VALID;
    logic [WIDTH-1:0] X;
    logic [2:0]       M;
    logic             OUT_VALID;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] PX;
    logic             CARRY;
    logic             ZERO;
    logic             OVF;
    logic             HIST_FULL;

    modport master (
        output IN_VALID, X, M,
        input  OUT_VALID, S, PX, CARRY, ZERO, OVF, HIST_FULL
    );

    modport slave (
        input  IN_VALID, X, M,
        output OUT_VALID, S, PX, CARRY, ZERO, OVF, HIST_FULL
    );
endinterface

// File: rtl/delta_alu_pipe.sv
// Streaming ALU stage: combines each accepted sample with the one accepted DEPTH samples earlier,
// plus an accumulator; one-cycle registered result with status flags.
module delta_alu_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    delta_alu_pipe_if.slave bus
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_OR   = 3'b010,
        OP_AND  = 3'b011,
        OP_XOR  = 3'b100,
        OP_ACC  = 3'b101,
        OP_LOAD = 3'b110,
        OP_MAX  = 3'b111
    } op_e;

    logic [WIDTH-1:0] hist [DEPTH];
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    fill;

    op_e              op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   acc_sum;
    logic             carry_n;
    logic             ovf_n;

    always_comb begin
        op       = op_e'(bus.M);
        x        = bus.X;
        p        = hist[DEPTH-1];
        sum      = {1'b0, x} + {1'b0, p};
        diff     = {1'b0, x} + {1'b0, ~p} + (WIDTH+1)'(1);
        acc_sum  = {1'b0, acc} + {1'b0, x};
        res      = '0;
        carry_n  = 1'b0;
        ovf_n    = 1'b0;
        acc_next = acc;
        case (op)
            OP_ADD: begin
                res     = sum[MSB:0];
                carry_n = sum[WIDTH];
                ovf_n   = (x[MSB] == p[MSB]) && (sum[MSB] != x[MSB]);
            end
            OP_SUB: begin
                // carry out of x + ~p + 1 is exactly the no-borrow (x >= p) condition
                res     = diff[MSB:0];
                carry_n = diff[WIDTH];
                ovf_n   = (x[MSB] != p[MSB]) && (diff[MSB] != x[MSB]);
            end
            OP_OR:  res = x | p;
            OP_AND: res = x & p;
            OP_XOR: res = x ^ p;
            OP_ACC: begin
                acc_next = acc_sum[MSB:0];
                res      = acc_sum[MSB:0];
                carry_n  = acc_sum[WIDTH];
                ovf_n    = (acc[MSB] == x[MSB]) && (acc_sum[MSB] != x[MSB]);
            end
            OP_LOAD: begin
                acc_next = x;
                res      = x;
            end
            OP_MAX: begin
                res     = (x >= p) ? x : p;
                carry_n = (x >= p);
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
            acc           <= '0;
            fill          <= '0;
            bus.OUT_VALID <= 1'b0;
            bus.S         <= '0;
            bus.PX        <= '0;
            bus.CARRY     <= 1'b0;
            bus.ZERO      <= 1'b0;
            bus.OVF       <= 1'b0;
            bus.HIST_FULL <= 1'b0;
        end else begin
            bus.OUT_VALID <= bus.IN_VALID;
            if (bus.IN_VALID) begin
                hist[0] <= x;
                for (int unsigned i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
                acc <= acc_next;
                if (fill != CW'(DEPTH)) fill <= fill + 1'b1;
                if (fill == CW'(DEPTH - 1)) bus.HIST_FULL <= 1'b1;
                bus.S     <= res;
                bus.PX    <= p;
                bus.CARRY <= carry_n;
                bus.ZERO  <= (res == '0);
                bus.OVF   <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_delta_alu_pipe.sv
// Directed bench for delta_alu_pipe: three instances (DEPTH 1/2/3) share one stimulus stream.
module tb_delta_alu_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] x = '0;
    logic [2:0] m = '0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    delta_alu_pipe_if #(.WIDTH(8)) b1 ();
    delta_alu_pipe_if #(.WIDTH(8)) b2 ();
    delta_alu_pipe_if #(.WIDTH(8)) b3 ();

    assign b1.IN_VALID = in_valid;
    assign b1.X = x;
    assign b1.M = m;
    assign b2.IN_VALID = in_valid;
    assign b2.X = x;
    assign b2.M = m;
    assign b3.IN_VALID = in_valid;
    assign b3.X = x;
    assign b3.M = m;

    delta_alu_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (.CLK(clk), .RST_N(rst_n), .bus(b1.slave));
    delta_alu_pipe #(.WIDTH(8), .DEPTH(2)) u_d2 (.CLK(clk), .RST_N(rst_n), .bus(b2.slave));
    delta_alu_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (.CLK(clk), .RST_N(rst_n), .bus(b3.slave));

    // {OUT_VALID, S, PX, CARRY, ZERO, OVF, HIST_FULL}
    logic [20:0] o1, o2, o3;
    assign o1 = {b1.OUT_VALID, b1.S, b1.PX, b1.CARRY, b1.ZERO, b1.OVF, b1.HIST_FULL};
    assign o2 = {b2.OUT_VALID, b2.S, b2.PX, b2.CARRY, b2.ZERO, b2.OVF, b2.HIST_FULL};
    assign o3 = {b3.OUT_VALID, b3.S, b3.PX, b3.CARRY, b3.ZERO, b3.OVF, b3.HIST_FULL};

    function automatic logic [20:0] pk(input logic ov, input logic [7:0] s, input logic [7:0] px,
                                       input logic c, input logic z, input logic o, input logic hf);
        return {ov, s, px, c, z, o, hf};
    endfunction

    task automatic chk(input string tag, input int d, input logic [20:0] e);
        logic [20:0] got;
        got = (d == 1) ? o1 : (d == 2) ? o2 : o3;
        n_cmp++;
        assert (got === e) else begin
            n_bad++;
            $error("FAIL %s (DEPTH=%0d): observed {ov,s,px,c,z,o,hf}=%h expected %h", tag, d, got, e);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] xv, input logic [2:0] mv);
        in_valid = v;
        x = xv;
        m = mv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_d1", 1, '0);
        chk("rst_d2", 2, '0);
        chk("rst_d3", 3, '0);

        // DEPTH=2 add chain
        step(1'b1, 8'd10, 3'b000); chk("d2_add1", 2, pk(1, 8'd10, 8'd0,  0, 0, 0, 0));
        step(1'b1, 8'd20, 3'b000); chk("d2_add2", 2, pk(1, 8'd20, 8'd0,  0, 0, 0, 1));
        step(1'b1, 8'd30, 3'b000); chk("d2_add3", 2, pk(1, 8'd40, 8'd10, 0, 0, 0, 1));

        // DEPTH=1 subtract with borrow
        do_reset();
        step(1'b1, 8'd10, 3'b001); chk("d1_sub1", 1, pk(1, 8'h0A, 8'h00, 1, 0, 0, 1));
        step(1'b1, 8'd5,  3'b001); chk("d1_sub2", 1, pk(1, 8'hFB, 8'h0A, 0, 0, 0, 1));

        // DEPTH=1 add overflow / carry
        do_reset();
        step(1'b1, 8'h70, 3'b000); chk("d1_ovf1", 1, pk(1, 8'h70, 8'h00, 0, 0, 0, 1));
        step(1'b1, 8'h70, 3'b000); chk("d1_ovf2", 1, pk(1, 8'hE0, 8'h70, 0, 0, 1, 1));
        step(1'b1, 8'h90, 3'b000); chk("d1_cry",  1, pk(1, 8'h00, 8'h70, 1, 1, 0, 1));

        // accumulator load / wrap
        do_reset();
        step(1'b1, 8'h80, 3'b110); chk("acc_load", 1, pk(1, 8'h80, 8'h00, 0, 0, 0, 1));
        step(1'b1, 8'h80, 3'b101); chk("acc_wrap", 1, pk(1, 8'h00, 8'h80, 1, 1, 1, 1));
        step(1'b1, 8'h03, 3'b101); chk("acc_add3", 1, pk(1, 8'h03, 8'h80, 0, 0, 0, 1));

        // logic / max / signed sub on DEPTH=1
        do_reset();
        step(1'b1, 8'h0C, 3'b000); chk("seed",    1, pk(1, 8'h0C, 8'h00, 0, 0, 0, 1));
        step(1'b1, 8'h0A, 3'b010); chk("or",      1, pk(1, 8'h0E, 8'h0C, 0, 0, 0, 1));
        step(1'b1, 8'h06, 3'b011); chk("and",     1, pk(1, 8'h02, 8'h0A, 0, 0, 0, 1));
        step(1'b1, 8'h03, 3'b100); chk("xor",     1, pk(1, 8'h05, 8'h06, 0, 0, 0, 1));
        step(1'b1, 8'h05, 3'b111); chk("max_x",   1, pk(1, 8'h05, 8'h03, 1, 0, 0, 1));
        step(1'b1, 8'h02, 3'b111); chk("max_p",   1, pk(1, 8'h05, 8'h05, 0, 0, 0, 1));
        step(1'b1, 8'h02, 3'b111); chk("max_tie", 1, pk(1, 8'h02, 8'h02, 1, 0, 0, 1));
        step(1'b1, 8'h80, 3'b001); chk("sub_ovf", 1, pk(1, 8'h7E, 8'h02, 1, 0, 1, 1));

        // DEPTH=3 with bubbles that must not age history
        do_reset();
        step(1'b1, 8'd1, 3'b000); chk("d3_a1", 3, pk(1, 8'd1, 8'd0, 0, 0, 0, 0));
        step(1'b1, 8'd2, 3'b000); chk("d3_a2", 3, pk(1, 8'd2, 8'd0, 0, 0, 0, 0));
        step(1'b0, 8'hFF, 3'b000); chk("d3_idle1", 3, pk(0, 8'd2, 8'd0, 0, 0, 0, 0));
        step(1'b0, 8'hFF, 3'b001);
        step(1'b0, 8'hFF, 3'b010);
        step(1'b0, 8'hFF, 3'b011); chk("d3_idle4", 3, pk(0, 8'd2, 8'd0, 0, 0, 0, 0));
        step(1'b1, 8'd3, 3'b000); chk("d3_a3", 3, pk(1, 8'd3, 8'd0, 0, 0, 0, 1));
        step(1'b1, 8'd7, 3'b000); chk("d3_a4", 3, pk(1, 8'd8, 8'd1, 0, 0, 0, 1));

        // DEPTH=2 asynchronous reset mid-stream
        do_reset();
        step(1'b1, 8'd1, 3'b000);
        step(1'b1, 8'd2, 3'b000);
        step(1'b1, 8'd3, 3'b000);
        step(1'b1, 8'd4, 3'b000);
        step(1'b1, 8'd5, 3'b000); chk("d2_pre", 2, pk(1, 8'd8, 8'd3, 0, 0, 0, 1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_d2", 2, '0);
        chk("async_d1", 1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'd9, 3'b000); chk("post_rst", 2, pk(1, 8'd9, 8'd0, 0, 0, 0, 0));
        step(1'b1, 8'd4, 3'b101); chk("acc_clr",  2, pk(1, 8'd4, 8'd0, 0, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
